// File: rtl/dec_scan_pkg.sv
// Shared encodings for the dec_scan decoder/scanner and its bench.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Prescaler width: enough bits to hold DIV-1, never less than one bit.
  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2**N one-hot decoder; all-zero output when en is low.
module dec_onehot #(
  parameter int N = 3
) (
  input  logic           en,
  input  logic [N-1:0]   code,
  output logic [2**N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[code] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with a direct-load mode and a prescaled auto-scan mode.
// All outputs are registered; out always reflects the index held alongside it.
module dec_scan
  import dec_scan_pkg::*;
#(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    in,
  input  logic            load,
  output logic [2**N-1:0] out,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int            PW      = presc_width(DIV);
  localparam logic [PW-1:0] TC      = PW'(DIV - 1);
  localparam logic [N-1:0]  IDX_MAX = '1;

  state_t          state, state_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [N-1:0]    idx_nxt;
  logic            wrap_nxt;
  logic [2**N-1:0] out_nxt;

  always_comb begin
    state_nxt = OFF;
    if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;

    idx_nxt   = idx;
    presc_nxt = presc;
    wrap_nxt  = 1'b0;

    case (state_nxt)
      DIRECT: begin
        presc_nxt = '0;
        if (load) idx_nxt = in;
      end
      SCAN: begin
        // The entry cycle only shows the current index; stepping starts afterwards.
        if (state != SCAN) begin
          presc_nxt = '0;
        end else if (presc == TC) begin
          presc_nxt = '0;
          idx_nxt   = idx + 1'b1;
          wrap_nxt  = (idx == IDX_MAX);
        end else begin
          presc_nxt = presc + 1'b1;
        end
      end
      default: ;
    endcase
  end

  dec_onehot #(.N(N)) u_dec (
    .en     (state_nxt != OFF),
    .code   (idx_nxt),
    .onehot (out_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      out   <= '0;
      idx   <= '0;
      presc <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      out   <= out_nxt;
      idx   <= idx_nxt;
      presc <= presc_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Scoreboard bench: dut_a (N=3, DIV=4) and dut_b (N=2, DIV=1) driven by directed vectors.
module tb_dec_scan;
  import dec_scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_en = 1'b0, a_mode = 1'b0, a_load = 1'b0;
  logic [2:0] a_in = '0;
  logic [7:0] a_out;
  logic [2:0] a_idx;
  logic       a_wrap;

  logic       b_rst = 1'b1, b_en = 1'b0, b_mode = 1'b0, b_load = 1'b0;
  logic [1:0] b_in = '0;
  logic [3:0] b_out;
  logic [1:0] b_idx;
  logic       b_wrap;

  dec_scan #(.N(3), .DIV(4)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .in(a_in), .load(a_load),
    .out(a_out), .idx(a_idx), .wrap(a_wrap)
  );

  dec_scan #(.N(2), .DIV(1)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .in(b_in), .load(b_load),
    .out(b_out), .idx(b_idx), .wrap(b_wrap)
  );

  typedef struct {
    logic [7:0] o;
    logic [2:0] i;
    logic       w;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step_a(input logic r, e, m, l, input logic [2:0] d,
                        input logic [7:0] eo, input logic [2:0] ei, input logic ew,
                        input string tag);
    exp_t x;
    @(negedge clk);
    a_rst = r; a_en = e; a_mode = m; a_load = l; a_in = d;
    x.o = eo; x.i = ei; x.w = ew; x.tag = tag;
    qa.push_back(x);
  endtask

  task automatic step_b(input logic r, e, m, input logic [3:0] eo,
                        input logic [1:0] ei, input logic ew, input string tag);
    exp_t x;
    @(negedge clk);
    b_rst = r; b_en = e; b_mode = m; b_load = 1'b0; b_in = 2'd0;
    x.o = {4'b0, eo}; x.i = {1'b0, ei}; x.w = ew; x.tag = tag;
    qb.push_back(x);
  endtask

  always begin : mon_a
    exp_t x;
    @(posedge clk);
    #1;
    if (qa.size() > 0) begin
      x = qa.pop_front();
      n_tests++;
      if (a_out !== x.o || a_idx !== x.i || a_wrap !== x.w) begin
        n_fail++;
        $display("FAIL a.%s: got out=%b idx=%0d wrap=%b, want out=%b idx=%0d wrap=%b",
                 x.tag, a_out, a_idx, a_wrap, x.o, x.i, x.w);
      end
    end
  end

  always begin : mon_b
    exp_t x;
    @(posedge clk);
    #1;
    if (qb.size() > 0) begin
      x = qb.pop_front();
      n_tests++;
      if ({4'b0, b_out} !== x.o || {1'b0, b_idx} !== x.i || b_wrap !== x.w) begin
        n_fail++;
        $display("FAIL b.%s: got out=%b idx=%0d wrap=%b, want out=%b idx=%0d wrap=%b",
                 x.tag, b_out, b_idx, b_wrap, x.o[3:0], x.i[1:0], x.w);
      end
      n_tests++;
      if (!$onehot0(b_out)) begin
        n_fail++;
        $display("FAIL b.onehot_%s: got out=%b, want at most one bit set", x.tag, b_out);
      end
    end
  end

  // Expected scan trajectory from idx=6 with DIV=4, one entry per cycle.
  logic [2:0] sc_idx [15] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7,
                              3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
  logic [1:0] b_exp_idx [12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                                 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic       b_exp_wrap [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    logic [7:0] one8;
    logic [3:0] one4;
    one8 = 8'd1;
    one4 = 4'd1;

    step_a(1, 0, MODE_DIRECT, 0, 3'd0, 8'h00, 3'd0, 0, "reset0");
    step_a(1, 1, MODE_SCAN,   1, 3'd4, 8'h00, 3'd0, 0, "reset_prio");
    step_a(0, 1, MODE_DIRECT, 1, 3'd5, 8'h20, 3'd5, 0, "load5");
    step_a(0, 1, MODE_DIRECT, 0, 3'd3, 8'h20, 3'd5, 0, "hold5");
    step_a(0, 1, MODE_DIRECT, 1, 3'd6, 8'h40, 3'd6, 0, "load6");

    for (int k = 0; k < 15; k++)
      step_a(0, 1, MODE_SCAN, 0, 3'd0, one8 << sc_idx[k], sc_idx[k], (k == 8), "scan6");

    for (int k = 0; k < 3; k++)
      step_a(0, 0, MODE_SCAN, 0, 3'd0, 8'h00, 3'd1, 0, "en_low");
    for (int k = 0; k < 4; k++)
      step_a(0, 1, MODE_SCAN, 0, 3'd0, 8'h02, 3'd1, 0, "resume");
    step_a(0, 1, MODE_SCAN, 0, 3'd0, 8'h04, 3'd2, 0, "resume_step");

    for (int k = 0; k < 3; k++)
      step_a(0, 1, MODE_SCAN, 1, 3'd2, 8'h04, 3'd2, 0, "scan_ignore_load");
    step_a(0, 1, MODE_SCAN, 1, 3'd2, 8'h08, 3'd3, 0, "scan_ignore_load");
    step_a(0, 1, MODE_SCAN, 1, 3'd2, 8'h08, 3'd3, 0, "scan_ignore_load");
    step_a(0, 1, MODE_DIRECT, 0, 3'd2, 8'h08, 3'd3, 0, "to_direct_hold");
    step_a(0, 1, MODE_DIRECT, 0, 3'd2, 8'h08, 3'd3, 0, "to_direct_hold");
    step_a(0, 1, MODE_DIRECT, 1, 3'd2, 8'h04, 3'd2, 0, "capture2");

    step_a(0, 1, MODE_DIRECT, 1, 3'd7, 8'h80, 3'd7, 0, "load7");
    for (int k = 0; k < 4; k++)
      step_a(0, 1, MODE_SCAN, 0, 3'd0, 8'h80, 3'd7, 0, "scan7");
    step_a(1, 1, MODE_SCAN, 0, 3'd0, 8'h00, 3'd0, 0, "rst_at_tc");
    step_a(0, 1, MODE_SCAN, 0, 3'd0, 8'h01, 3'd0, 0, "post_rst_scan");
    step_a(0, 0, MODE_SCAN, 0, 3'd0, 8'h00, 3'd0, 0, "off_again");
    step_a(0, 1, MODE_DIRECT, 0, 3'd5, 8'h01, 3'd0, 0, "off_to_direct");

    step_b(1, 0, MODE_DIRECT, 4'h0, 2'd0, 0, "reset");
    step_b(1, 1, MODE_SCAN,   4'h0, 2'd0, 0, "reset_prio");
    for (int k = 0; k < 12; k++)
      step_b(0, 1, MODE_SCAN, one4 << b_exp_idx[k], b_exp_idx[k], b_exp_wrap[k], "div1_scan");
    step_b(0, 0, MODE_SCAN, 4'h0, 2'd3, 0, "off");

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
